apb_timeout_interconnect: RTL and testbench
===========================================

APB_TIMEOUT_INTERCONNECT -- requirements
Module: apb_timeout_interconnect

Interface
REQ-001 SHALL have parameter DW, default 32, data width.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter NUM_PERIPHERALS, default 8, external slave count (1..64).
REQ-004 SHALL have parameter NUM_REG_PERIPHERAL, default 32, 32-bit registers per slot (power of 2).
REQ-005 SHALL have parameter TIMEOUT, default 255, max access-phase wait cycles (1..65535).
REQ-006 SHALL have one clock; reset is synchronous and active-high. Ports: clock (input, 1, rising-edge clock); reset (input, 1, synchronous active-high reset).
REQ-007 SHALL have master ports MpADDR in AW, MpSELx in 1, MpENABLE in 1, MpWRITE in 1, MpWDATA in DW, MpRDATA out DW, MpREADY out 1, MpSLVERR out 1.
REQ-008 SHALL have slave ports, unpacked [NUM_PERIPHERALS-1:0]: SpADDR out AW, SpSEL out 1, SpENABLE out 1, SpWRITE out 1, SpWDATA out DW, SpRDATA in DW, SpREADY in 1, SpSLVERR in 1.

Function
REQ-009 SHALL decode slot index = MpADDR >> (2+log2(NUM_REG_PERIPHERAL)); SpADDR = local offset (index bits zeroed).
REQ-010 SHALL treat index NUM_PERIPHERALS as internal status slot; index > NUM_PERIPHERALS is a decode error.
REQ-011 SHALL use FSM states IDLE, ACCESS, ERR_RESP; IDLE->ACCESS on MpSELx & !MpENABLE, latching index, address, write, wdata.
REQ-012 SHALL drive latched fields to the selected slave only; SpSEL high from ACCESS entry, SpENABLE high while in ACCESS with MpENABLE; all other slaves SpSEL=SpENABLE=0.
REQ-013 SHALL pass selected slave SpRDATA, SpREADY, SpSLVERR combinationally to master in ACCESS; ACCESS->IDLE when MpREADY=1.
REQ-014 SHALL count access-phase cycles with SpREADY=0 in 16-bit counter, cleared on ACCESS entry; reaching TIMEOUT -> ERR_RESP, SpSEL/SpENABLE dropped that same edge.
REQ-015 SHALL, in ERR_RESP, drive MpREADY=1, MpSLVERR=1, MpRDATA=32'hDEADBEEF for exactly one cycle, then IDLE.
REQ-016 SHALL answer decode errors in first access cycle: MpREADY=1, MpSLVERR=1, MpRDATA=32'hDEADBEEF, no slave selected.
REQ-017 SHALL answer status slot with zero wait: MpREADY=1, MpSLVERR=0 in first access cycle.
REQ-018 SHALL provide status registers: 0x0 ERR_COUNT (16-bit, saturates at 0xFFFF; any write clears); 0x4 LAST_ERR_ADDR (RO); 0x8 LAST_ERR_CAUSE (RO, bit0 timeout, bit1 decode, bit2 slave SLVERR); other offsets read 0, writes ignored.
REQ-019 SHALL increment ERR_COUNT and update LAST_ERR_ADDR/CAUSE once per erroneous transfer, at its completing cycle.
REQ-020 SHALL give a write-clear to ERR_COUNT priority over a simultaneous increment (result 0).
REQ-021 SHALL, when no transfer is in progress, drive MpREADY=0, MpSLVERR=0, MpRDATA=0.

Reset
REQ-022 SHALL on reset force IDLE, timeout counter 0, ERR_COUNT 0, LAST_ERR_ADDR 0, LAST_ERR_CAUSE 0, all SpSEL/SpENABLE/SpWRITE 0, SpADDR/SpWDATA 0, MpREADY/MpSLVERR 0, MpRDATA 0.
REQ-023 SHALL on reset mid-transfer abandon it with no response and no error logged.

Structure
REQ-024 SHALL place state enum, status offsets, cause-bit positions and ERR_RDATA constant 32'hDEADBEEF in package apb_ic_pkg.
REQ-025 SHALL implement status registers in sub-module apb_ic_status.

Verification
REQ-026 SHALL verify: write 0x1234 to slot 2 offset 0x8, slave READY after 3 waits -> Sp slot 2 sees SpADDR=0x8, MpREADY on 4th access cycle, SLVERR=0.
REQ-027 SHALL verify: TIMEOUT=4, slot 1 READY stuck 0 -> SpSEL[1] drops after 4 cycles, one-cycle MpREADY=1/SLVERR=1/RDATA=0xDEADBEEF, ERR_COUNT=1, CAUSE=0x1.
REQ-028 SHALL verify: NUM_PERIPHERALS=8, read address with index 9 -> immediate SLVERR, no SpSEL asserted, CAUSE=0x2, LAST_ERR_ADDR=address.
REQ-029 SHALL verify: ERR_COUNT preset 0xFFFF plus one more error -> stays 0xFFFF; write to 0x0 coinciding with error -> 0.
REQ-030 SHALL verify: reset asserted during ACCESS on slot 0 -> next cycle all outputs at reset values, ERR_COUNT unchanged at 0.

Source files
------------

// File: rtl/apb_ic_pkg.sv
// Shared types and constants for the APB timeout interconnect.
// Holds the FSM states, status register map and error-cause bit positions.
package apb_ic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR_RESP
    } state_e;

    typedef enum logic [1:0] {
        TGT_SLAVE,
        TGT_STATUS,
        TGT_DECERR
    } tgt_e;

    localparam int unsigned STAT_ERR_COUNT  = 32'h0;
    localparam int unsigned STAT_LAST_ADDR  = 32'h4;
    localparam int unsigned STAT_LAST_CAUSE = 32'h8;

    localparam int unsigned CAUSE_W       = 3;
    localparam int unsigned CAUSE_TIMEOUT = 0;
    localparam int unsigned CAUSE_DECODE  = 1;
    localparam int unsigned CAUSE_SLVERR  = 2;

    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/apb_ic_status.sv
// Internal status slot: saturating error counter plus last error address/cause.
// A clear wins over a same-cycle error event.
module apb_ic_status
    import apb_ic_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned OFF_W = 7,
    parameter int unsigned CNT_W = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clr,
    input  logic               i_err,
    input  logic [AW-1:0]      i_err_addr,
    input  logic [CAUSE_W-1:0] i_err_cause,
    input  logic [OFF_W-1:0]   i_rd_off,
    output logic [DW-1:0]      o_rdata
);

    logic [CNT_W-1:0]   r_err_count;
    logic [AW-1:0]      r_last_addr;
    logic [CAUSE_W-1:0] r_last_cause;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_err_count  <= '0;
            r_last_addr  <= '0;
            r_last_cause <= '0;
        end else begin
            if (i_clr) begin
                r_err_count <= '0;
            end else if (i_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (i_err) begin
                r_last_addr  <= i_err_addr;
                r_last_cause <= i_err_cause;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_rd_off)
            OFF_W'(STAT_ERR_COUNT):  o_rdata = DW'(r_err_count);
            OFF_W'(STAT_LAST_ADDR):  o_rdata = DW'(r_last_addr);
            OFF_W'(STAT_LAST_CAUSE): o_rdata = DW'(r_last_cause);
            default:                 o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/apb_timeout_interconnect.sv
// APB 1-to-N interconnect with address decode, per-transfer wait timeout and
// an internal status slot that logs timeouts, decode errors and slave errors.
module apb_timeout_interconnect
    import apb_ic_pkg::*;
#(
    parameter int unsigned DW                 = 32,
    parameter int unsigned AW                 = 32,
    parameter int unsigned NUM_PERIPHERALS    = 8,
    parameter int unsigned NUM_REG_PERIPHERAL = 32,
    parameter int unsigned TIMEOUT            = 255
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] MpADDR,
    input  logic          MpSELx,
    input  logic          MpENABLE,
    input  logic          MpWRITE,
    input  logic [DW-1:0] MpWDATA,
    output logic [DW-1:0] MpRDATA,
    output logic          MpREADY,
    output logic          MpSLVERR,
    output logic [AW-1:0] SpADDR   [NUM_PERIPHERALS-1:0],
    output logic          SpSEL    [NUM_PERIPHERALS-1:0],
    output logic          SpENABLE [NUM_PERIPHERALS-1:0],
    output logic          SpWRITE  [NUM_PERIPHERALS-1:0],
    output logic [DW-1:0] SpWDATA  [NUM_PERIPHERALS-1:0],
    input  logic [DW-1:0] SpRDATA  [NUM_PERIPHERALS-1:0],
    input  logic          SpREADY  [NUM_PERIPHERALS-1:0],
    input  logic          SpSLVERR [NUM_PERIPHERALS-1:0]
);

    localparam int unsigned SHIFT  = 2 + $clog2(NUM_REG_PERIPHERAL);
    localparam int unsigned SLOT_W = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;
    localparam logic [AW-1:0] OFF_MASK = AW'((64'd1 << SHIFT) - 64'd1);

    state_e              r_state;
    tgt_e                r_tgt;
    logic [SLOT_W-1:0]   r_slot;
    logic [AW-1:0]       r_addr;
    logic                r_write;
    logic [DW-1:0]       r_wdata;
    logic [15:0]         r_cnt;

    logic [AW-1:0]       w_idx;
    tgt_e                w_tgt;
    logic [15:0]         w_cnt_nxt;
    logic                w_active;
    logic                w_err;
    logic                w_clr;
    logic [CAUSE_W-1:0]  w_cause;
    logic [DW-1:0]       w_stat_rdata;

    assign w_idx     = MpADDR >> SHIFT;
    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_active  = (r_state == ACCESS) && (r_tgt == TGT_SLAVE);

    always_comb begin
        if (w_idx < AW'(NUM_PERIPHERALS))       w_tgt = TGT_SLAVE;
        else if (w_idx == AW'(NUM_PERIPHERALS)) w_tgt = TGT_STATUS;
        else                                    w_tgt = TGT_DECERR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_tgt   <= TGT_SLAVE;
            r_slot  <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MpSELx && !MpENABLE) begin
                        r_state <= ACCESS;
                        r_tgt   <= w_tgt;
                        r_slot  <= w_idx[SLOT_W-1:0];
                        r_addr  <= MpADDR;
                        r_write <= MpWRITE;
                        r_wdata <= MpWDATA;
                        r_cnt   <= '0;
                    end
                end
                ACCESS: begin
                    // Only a slave target can stall; MpREADY low here means SpREADY low.
                    if (MpREADY) begin
                        r_state <= IDLE;
                    end else if (r_tgt == TGT_SLAVE) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == 16'(TIMEOUT)) r_state <= ERR_RESP;
                    end
                end
                ERR_RESP: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        MpREADY  = 1'b0;
        MpSLVERR = 1'b0;
        MpRDATA  = '0;
        w_err    = 1'b0;
        w_clr    = 1'b0;
        w_cause  = '0;
        case (r_state)
            ACCESS: begin
                case (r_tgt)
                    TGT_SLAVE: begin
                        MpREADY  = SpREADY[r_slot];
                        MpSLVERR = SpSLVERR[r_slot];
                        MpRDATA  = SpRDATA[r_slot];
                        if (SpREADY[r_slot] && SpSLVERR[r_slot]) begin
                            w_err                 = 1'b1;
                            w_cause[CAUSE_SLVERR] = 1'b1;
                        end
                    end
                    TGT_STATUS: begin
                        MpREADY = 1'b1;
                        MpRDATA = w_stat_rdata;
                        w_clr   = r_write && (r_addr[SHIFT-1:0] == SHIFT'(STAT_ERR_COUNT));
                    end
                    default: begin
                        MpREADY               = 1'b1;
                        MpSLVERR              = 1'b1;
                        MpRDATA               = DW'(ERR_RDATA);
                        w_err                 = 1'b1;
                        w_cause[CAUSE_DECODE] = 1'b1;
                    end
                endcase
            end
            ERR_RESP: begin
                MpREADY                = 1'b1;
                MpSLVERR               = 1'b1;
                MpRDATA                = DW'(ERR_RDATA);
                w_err                  = 1'b1;
                w_cause[CAUSE_TIMEOUT] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_PERIPHERALS; i++) begin
            SpSEL[i]    = 1'b0;
            SpENABLE[i] = 1'b0;
            SpWRITE[i]  = 1'b0;
            SpADDR[i]   = '0;
            SpWDATA[i]  = '0;
            if (w_active && (r_slot == SLOT_W'(i))) begin
                SpSEL[i]    = 1'b1;
                SpENABLE[i] = MpENABLE;
                SpWRITE[i]  = r_write;
                SpADDR[i]   = r_addr & OFF_MASK;
                SpWDATA[i]  = r_wdata;
            end
        end
    end

    apb_ic_status #(
        .DW   (DW),
        .AW   (AW),
        .OFF_W(SHIFT),
        .CNT_W(16)
    ) u_status (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clr      (w_clr),
        .i_err      (w_err),
        .i_err_addr (r_addr),
        .i_err_cause(w_cause),
        .i_rd_off   (r_addr[SHIFT-1:0]),
        .o_rdata    (w_stat_rdata)
    );

endmodule

// File: tb/tb_apb_timeout_interconnect.sv
// Randomized bench for apb_timeout_interconnect against a transfer-level model,
// plus a reduced-width status block instance to reach counter saturation quickly.
module tb_apb_timeout_interconnect;
    localparam int NP = 8;
    localparam int SH = 7;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_sel, m_en, m_write, m_ready, m_slverr;
    logic [31:0] sp_addr   [NP-1:0];
    logic        sp_sel    [NP-1:0];
    logic        sp_en     [NP-1:0];
    logic        sp_write  [NP-1:0];
    logic [31:0] sp_wdata  [NP-1:0];
    logic [31:0] sp_rdata  [NP-1:0];
    logic        sp_ready  [NP-1:0];
    logic        sp_slverr [NP-1:0];

    int unsigned slv_wait  [NP-1:0];
    logic        slv_err   [NP-1:0];
    logic [31:0] slv_rdata [NP-1:0];
    int unsigned slv_cnt   [NP-1:0];

    logic [NP-1:0] sel_vec, en_vec, wr_vec;
    logic [31:0]   data_or;

    logic        st_clr = 1'b0, st_err = 1'b0;
    logic [31:0] st_addr = '0, st_rdata;
    logic [2:0]  st_cause = '0;
    logic [6:0]  st_off = '0;

    logic [15:0] m_cnt;
    logic [31:0] m_last_addr;
    logic [2:0]  m_last_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_timeout_interconnect #(
        .DW(32), .AW(32), .NUM_PERIPHERALS(NP), .NUM_REG_PERIPHERAL(32), .TIMEOUT(TO)
    ) dut (
        .clock(clk), .reset(rst),
        .MpADDR(m_addr), .MpSELx(m_sel), .MpENABLE(m_en), .MpWRITE(m_write),
        .MpWDATA(m_wdata), .MpRDATA(m_rdata), .MpREADY(m_ready), .MpSLVERR(m_slverr),
        .SpADDR(sp_addr), .SpSEL(sp_sel), .SpENABLE(sp_en), .SpWRITE(sp_write),
        .SpWDATA(sp_wdata), .SpRDATA(sp_rdata), .SpREADY(sp_ready), .SpSLVERR(sp_slverr)
    );

    // 4-bit counter so saturation is reachable in a few cycles
    apb_ic_status #(.DW(32), .AW(32), .OFF_W(7), .CNT_W(4)) u_stat (
        .i_clock(clk), .i_reset(rst), .i_clr(st_clr), .i_err(st_err),
        .i_err_addr(st_addr), .i_err_cause(st_cause), .i_rd_off(st_off), .o_rdata(st_rdata)
    );

    // Slaves: READY rises after slv_wait access cycles
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            sp_ready[i]  = sp_sel[i] && sp_en[i] && (slv_cnt[i] >= slv_wait[i]);
            sp_slverr[i] = slv_err[i];
            sp_rdata[i]  = slv_rdata[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (!sp_sel[i])                    slv_cnt[i] <= 0;
            else if (sp_en[i] && !sp_ready[i]) slv_cnt[i] <= slv_cnt[i] + 1;
        end
    end

    always_comb begin
        data_or = '0;
        for (int i = 0; i < NP; i++) begin
            sel_vec[i] = sp_sel[i];
            en_vec[i]  = sp_en[i];
            wr_vec[i]  = sp_write[i];
            data_or    = data_or | sp_addr[i] | sp_wdata[i];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt        = '0;
        m_last_addr  = '0;
        m_last_cause = '0;
    endtask

    // Expected response of one transfer; status reads see pre-transfer state
    task automatic model_xfer(input logic [31:0] addr, input logic wr,
                              output logic [31:0] e_rd, output logic e_err,
                              output int unsigned e_cyc, output int unsigned e_sel);
        logic [31:0] idx;
        logic [6:0]  off;
        logic [2:0]  cause;
        int unsigned s;
        bit          clr;
        idx   = addr >> SH;
        off   = addr[6:0];
        cause = '0;
        clr   = 0;
        e_rd  = '0;
        if (idx < NP) begin
            s = idx;
            if (slv_wait[s] >= TO) begin
                e_cyc = TO + 1; e_sel = TO; e_err = 1'b1; e_rd = 32'hDEADBEEF; cause = 3'b001;
            end else begin
                e_cyc = slv_wait[s] + 1; e_sel = e_cyc; e_err = slv_err[s]; e_rd = slv_rdata[s];
                if (slv_err[s]) cause = 3'b100;
            end
        end else if (idx == NP) begin
            e_cyc = 1; e_sel = 0; e_err = 1'b0;
            case (off)
                7'h00:   e_rd = {16'h0, m_cnt};
                7'h04:   e_rd = m_last_addr;
                7'h08:   e_rd = {29'h0, m_last_cause};
                default: e_rd = '0;
            endcase
            clr = wr && (off == 7'h00);
        end else begin
            e_cyc = 1; e_sel = 0; e_err = 1'b1; e_rd = 32'hDEADBEEF; cause = 3'b010;
        end
        if (clr) m_cnt = '0;
        if (cause != 3'b000) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_last_addr  = addr;
            m_last_cause = cause;
        end
    endtask

    // Runs one master transfer starting just after a rising edge
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           output logic [31:0] rd);
        logic [31:0] e_rd, idx, o_rd, c_addr, c_wd;
        logic        e_err, o_err, c_wr, c_en, to_slave;
        int unsigned e_cyc, e_sel, cyc, sel_cyc, wrong;
        bit          got_rdy;
        idx = addr >> SH;
        to_slave = (idx < NP);
        model_xfer(addr, wr, e_rd, e_err, e_cyc, e_sel);
        cyc = 0; sel_cyc = 0; wrong = 0; got_rdy = 0;
        o_rd = '0; o_err = 1'b0; c_addr = '0; c_wd = '0; c_wr = 1'b0; c_en = 1'b0;
        m_addr = addr; m_write = wr; m_wdata = wd; m_sel = 1'b1; m_en = 1'b0;
        @(posedge clk); #1;
        m_en = 1'b1;
        while (!got_rdy && cyc < 40) begin
            @(negedge clk);
            cyc++;
            for (int j = 0; j < NP; j++) begin
                if (sp_sel[j]) begin
                    if (to_slave && j == idx) begin
                        if (sel_cyc == 0) begin
                            c_addr = sp_addr[j]; c_wd = sp_wdata[j]; c_wr = sp_write[j]; c_en = sp_en[j];
                        end
                        sel_cyc++;
                    end else begin
                        wrong++;
                    end
                end
            end
            if (m_ready) begin
                got_rdy = 1; o_rd = m_rdata; o_err = m_slverr;
            end
            @(posedge clk); #1;
        end
        m_sel = 1'b0; m_en = 1'b0;
        check_eq($sformatf("done@%h", addr), 32'(got_rdy), 32'd1);
        check_eq($sformatf("rdata@%h", addr), o_rd, e_rd);
        check_eq($sformatf("slverr@%h", addr), 32'(o_err), 32'(e_err));
        check_eq($sformatf("cycles@%h", addr), cyc, e_cyc);
        check_eq($sformatf("selcyc@%h", addr), sel_cyc, e_sel);
        check_eq($sformatf("othersel@%h", addr), wrong, 32'd0);
        if (to_slave) begin
            check_eq($sformatf("spaddr@%h", addr), c_addr, addr & 32'h7F);
            check_eq($sformatf("spwrite@%h", addr), 32'(c_wr), 32'(wr));
            check_eq($sformatf("spwdata@%h", addr), c_wd, wd);
            check_eq($sformatf("spen@%h", addr), 32'(c_en), 32'd1);
        end
        rd = o_rd;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_eq({pfx, "_mready"}, 32'(m_ready), 32'd0);
        check_eq({pfx, "_mslverr"}, 32'(m_slverr), 32'd0);
        check_eq({pfx, "_mrdata"}, m_rdata, 32'd0);
        check_eq({pfx, "_spsel"}, 32'(sel_vec), 32'd0);
        check_eq({pfx, "_spen"}, 32'(en_vec), 32'd0);
        check_eq({pfx, "_spwrite"}, 32'(wr_vec), 32'd0);
        check_eq({pfx, "_spdata"}, data_or, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, addr;
        int unsigned s, r, w;
        rst = 1'b1;
        m_addr = '0; m_wdata = '0; m_sel = 1'b0; m_en = 1'b0; m_write = 1'b0;
        for (int i = 0; i < NP; i++) begin
            slv_wait[i] = 0; slv_err[i] = 1'b0; slv_rdata[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        do_xfer(32'h400, 1'b0, '0, rd);

        // Write 0x1234 to slot 2 offset 0x8, three wait states
        slv_wait[2] = 3; slv_err[2] = 1'b0; slv_rdata[2] = 32'h0BAD_F00D;
        do_xfer(32'h108, 1'b1, 32'h1234, rd);

        // Reset in the middle of a stalled access to slot 0
        slv_wait[0] = 1000; slv_err[0] = 1'b0;
        m_addr = 32'h10; m_write = 1'b1; m_wdata = 32'h55; m_sel = 1'b1; m_en = 1'b0;
        @(posedge clk); #1;
        m_en = 1'b1;
        @(negedge clk);
        check_eq("rstmid_sel", 32'(sel_vec), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_sel = 1'b0; m_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("rstmid");
        model_reset();
        repeat (TO + 2) @(posedge clk);
        #1;
        do_xfer(32'h400, 1'b0, '0, rd);
        check_eq("rstmid_errcnt", rd, 32'd0);

        // Slot 1 never ready: timeout response
        slv_wait[1] = 1000; slv_err[1] = 1'b0;
        do_xfer(32'h84, 1'b0, '0, rd);
        check_eq("to_rdata", rd, 32'hDEADBEEF);
        do_xfer(32'h400, 1'b0, '0, rd);
        check_eq("to_errcnt", rd, 32'd1);
        do_xfer(32'h408, 1'b0, '0, rd);
        check_eq("to_cause", rd, 32'h1);

        // Index 9 with 8 slaves: decode error
        do_xfer(32'h480, 1'b0, '0, rd);
        do_xfer(32'h408, 1'b0, '0, rd);
        check_eq("dec_cause", rd, 32'h2);
        do_xfer(32'h404, 1'b0, '0, rd);
        check_eq("dec_addr", rd, 32'h480);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                s = $urandom_range(0, NP - 1);
                addr = (s << SH) | ($urandom_range(0, 31) << 2);
                w = $urandom_range(0, 9);
                slv_wait[s]  = (w < 6) ? (w % 3) : (w < 8) ? 3 : (w == 8) ? TO : 50;
                slv_err[s]   = ($urandom_range(0, 3) == 0);
                slv_rdata[s] = $urandom();
            end else if (r < 85) begin
                addr = 32'h400 | ($urandom_range(0, 4) << 2);
            end else if (r < 95) begin
                addr = ($urandom_range(9, 15) << SH) | ($urandom_range(0, 31) << 2);
            end else begin
                addr = $urandom() | 32'h8000_0000;
            end
            do_xfer(addr, 1'($urandom_range(0, 1)), $urandom(), rd);
        end

        // Saturation and clear-over-increment on the status block
        st_off = 7'h00; st_cause = 3'b001;
        for (int k = 0; k < 14; k++) begin
            st_err = 1'b1; st_addr = 32'h1000 + k;
            @(posedge clk); #1;
        end
        st_err = 1'b0;
        @(negedge clk);
        check_eq("sub_cnt14", st_rdata, 32'd14);
        st_err = 1'b1; st_addr = 32'hA5A5_0000; st_cause = 3'b100;
        @(posedge clk); #1;
        st_err = 1'b0;
        @(negedge clk);
        check_eq("sub_cnt15", st_rdata, 32'd15);
        st_err = 1'b1; st_addr = 32'h0000_BEEF; st_cause = 3'b010;
        @(posedge clk); #1;
        st_err = 1'b0;
        @(negedge clk);
        check_eq("sub_sat", st_rdata, 32'd15);
        st_off = 7'h04; #1;
        check_eq("sub_addr", st_rdata, 32'h0000_BEEF);
        st_off = 7'h08; #1;
        check_eq("sub_cause", st_rdata, 32'h2);
        st_off = 7'h0C; #1;
        check_eq("sub_other", st_rdata, 32'd0);
        st_off = 7'h00;
        @(posedge clk); #1;
        st_err = 1'b1; st_clr = 1'b1;
        @(posedge clk); #1;
        st_err = 1'b0; st_clr = 1'b0;
        @(negedge clk);
        check_eq("sub_clr_prio", st_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
